// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: turns host read/program/erase/clear commands into
// Intel StrataFlash bus-cycle sequences on the memory controller flash port.
`timescale 1ns/1ps
module flash_cmd_sequencer #(
    parameter int                    POLL_WIDTH = 24,
    parameter logic [POLL_WIDTH-1:0] POLL_LIMIT = 24'd4000000,
    parameter logic [7:0]            POLL_GAP   = 8'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [22:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic        done,
    output logic [15:0] rdata,
    output logic [7:0]  status,
    output logic        error,
    output logic [22:0] mem_address,
    output logic [15:0] mem_to_mem,
    input  logic [15:0] mem_from_mem,
    output logic        mem_req,
    output logic        mem_wren,
    input  logic        mem_ready
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARRAY,
        S_READ,
        S_CMD1,
        S_CMD2,
        S_GAP,
        S_POLL,
        S_DONE
    } state_t;

    state_t                state, state_n;
    logic [1:0]            op, op_n;
    logic [22:0]           addr, addr_n;
    logic [15:0]           data, data_n;
    logic                  req_n, wren_n;
    logic [22:0]           maddr_n;
    logic [15:0]           mto_n;
    logic [15:0]           rdata_n;
    logic [7:0]            status_n;
    logic                  error_n;
    logic                  array_mode, array_n;
    logic [POLL_WIDTH-1:0] poll_cnt, poll_n, poll_inc;
    logic [7:0]            gap_cnt, gap_n, gap_inc;
    logic                  rdy;
    logic                  to_done;
    logic                  timeout;

    // A ready pulse only counts once the request cycle itself is over.
    assign rdy       = mem_ready && !mem_req;
    assign poll_inc  = poll_cnt + POLL_WIDTH'(1);
    assign gap_inc   = gap_cnt + 8'd1;
    assign cmd_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);

    always_comb begin
        state_n  = state;
        op_n     = op;
        addr_n   = addr;
        data_n   = data;
        req_n    = 1'b0;
        wren_n   = mem_wren;
        maddr_n  = mem_address;
        mto_n    = mem_to_mem;
        rdata_n  = rdata;
        status_n = status;
        error_n  = error;
        array_n  = array_mode;
        poll_n   = poll_cnt;
        gap_n    = gap_cnt;
        to_done  = 1'b0;
        timeout  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_n    = cmd_op;
                    addr_n  = cmd_addr;
                    data_n  = cmd_data;
                    error_n = 1'b0;
                    poll_n  = '0;
                    req_n   = 1'b1;
                    maddr_n = cmd_addr;
                    if (cmd_op == OP_READ && !array_mode) begin
                        state_n = S_ARRAY;
                        wren_n  = 1'b1;
                        mto_n   = 16'h00FF;
                    end else if (cmd_op == OP_READ) begin
                        state_n = S_READ;
                        wren_n  = 1'b0;
                    end else begin
                        state_n = S_CMD1;
                        wren_n  = 1'b1;
                        case (cmd_op)
                            OP_PROG:  mto_n = 16'h0040;
                            OP_ERASE: mto_n = 16'h0020;
                            default:  mto_n = 16'h0050;
                        endcase
                    end
                end
            end
            S_ARRAY: begin
                if (rdy) begin
                    array_n = 1'b1;
                    state_n = S_READ;
                    req_n   = 1'b1;
                    wren_n  = 1'b0;
                    maddr_n = addr;
                end
            end
            S_READ: begin
                if (rdy) begin
                    rdata_n = mem_from_mem;
                    to_done = 1'b1;
                end
            end
            S_CMD1: begin
                if (rdy) begin
                    array_n = 1'b0;
                    if (op == OP_CLEAR) begin
                        to_done = 1'b1;
                    end else begin
                        state_n = S_CMD2;
                        req_n   = 1'b1;
                        wren_n  = 1'b1;
                        maddr_n = addr;
                        mto_n   = (op == OP_PROG) ? data : 16'h00D0;
                    end
                end
            end
            S_CMD2: begin
                if (rdy) begin
                    state_n = S_GAP;
                    gap_n   = '0;
                end
            end
            S_GAP: begin
                gap_n = gap_inc;
                if (gap_inc == POLL_GAP) begin
                    state_n = S_POLL;
                    gap_n   = '0;
                    req_n   = 1'b1;
                    wren_n  = 1'b0;
                    maddr_n = addr;
                end
            end
            S_POLL: begin
                if (rdy) begin
                    status_n = mem_from_mem[7:0];
                    poll_n   = poll_inc;
                    if (mem_from_mem[7]) begin
                        to_done = 1'b1;
                    end else if (poll_inc == POLL_LIMIT) begin
                        timeout = 1'b1;
                        to_done = 1'b1;
                    end else begin
                        state_n = S_GAP;
                        gap_n   = '0;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Error is latched on the way into S_DONE so it is valid with done.
        if (to_done) begin
            state_n = S_DONE;
            error_n = timeout || ((status_n & 8'h3A) != 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op          <= OP_READ;
            addr        <= '0;
            data        <= '0;
            mem_req     <= 1'b0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_to_mem  <= '0;
            rdata       <= '0;
            status      <= '0;
            error       <= 1'b0;
            array_mode  <= 1'b0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_n;
            op          <= op_n;
            addr        <= addr_n;
            data        <= data_n;
            mem_req     <= req_n;
            mem_wren    <= wren_n;
            mem_address <= maddr_n;
            mem_to_mem  <= mto_n;
            rdata       <= rdata_n;
            status      <= status_n;
            error       <= error_n;
            array_mode  <= array_n;
            poll_cnt    <= poll_n;
            gap_cnt     <= gap_n;
        end
    end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: scoreboard bench with a StrataFlash bus model
// behind the sequencer; expected accesses and results are queued per command.
`timescale 1ns/1ps
module tb_flash_cmd_sequencer;

    localparam int         LAT   = 2;
    localparam logic [7:0] GAP   = 8'd8;
    localparam int         BOUND = 3000;

    typedef struct packed {
        logic        wren;
        logic [22:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic [7:0]  status;
        logic        error;
        logic        cr;
        logic        cs;
        logic        ce;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [22:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        cmd_ready;
    logic        done;
    logic [15:0] rdata;
    logic [7:0]  status;
    logic        error;
    logic [22:0] mem_address;
    logic [15:0] mem_to_mem;
    logic [15:0] mem_from_mem = '0;
    logic        mem_req;
    logic        mem_wren;
    logic        mem_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    acc_t       exp_acc[$];
    res_t       exp_res[$];
    logic [7:0] stat_q[$];
    logic [7:0] stat_stuck = 8'h00;
    int         mode = 0;
    int         poll_reads = 0;
    int         req_cyc = 0;
    int         rdy_cyc = 0;
    bit         pend = 0;
    int         cnt = 0;
    logic [15:0] resp = '0;
    bit         req_prev = 0;

    flash_cmd_sequencer #(
        .POLL_WIDTH(24),
        .POLL_LIMIT(24'd5),
        .POLL_GAP(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .done(done),
        .rdata(rdata),
        .status(status),
        .error(error),
        .mem_address(mem_address),
        .mem_to_mem(mem_to_mem),
        .mem_from_mem(mem_from_mem),
        .mem_req(mem_req),
        .mem_wren(mem_wren),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] word_of(input logic [22:0] a);
        return (a == 23'h10) ? 16'hBEEF : (a[15:0] ^ 16'hC3C3);
    endfunction

    // Flash + controller model: one access in flight, ready LAT+1 cycles on.
    always @(negedge clk) begin
        acc_t e;
        mem_ready = 1'b0;
        if (mem_req) begin
            n_chk++;
            if (pend || req_prev) begin
                n_fail++;
                $display("FAIL req_protocol: pend=%0d prev_req=%0d cyc=%0d, required idle bus", pend, req_prev, cyc);
            end
            n_chk++;
            if (exp_acc.size() == 0) begin
                n_fail++;
                $display("FAIL access_extra: wren=%b addr=%h data=%h, required none", mem_wren, mem_address, mem_to_mem);
            end else begin
                e = exp_acc.pop_front();
                if (mem_wren !== e.wren || mem_address !== e.addr || (e.wren && mem_to_mem !== e.data)) begin
                    n_fail++;
                    $display("FAIL access: wren=%b addr=%h data=%h, required wren=%b addr=%h data=%h", mem_wren, mem_address, mem_to_mem, e.wren, e.addr, e.data);
                end
            end
            if (!mem_wren && mode == 1) begin
                n_chk++;
                if (cyc - rdy_cyc - 1 != int'(GAP)) begin
                    n_fail++;
                    $display("FAIL poll_gap: %0d idle cycles, required %0d", cyc - rdy_cyc - 1, GAP);
                end
                poll_reads++;
                resp = (stat_q.size() != 0) ? {8'h00, stat_q.pop_front()} : {8'h00, stat_stuck};
            end else if (!mem_wren) begin
                resp = word_of(mem_address);
            end else begin
                resp = 16'h0000;
                if (mode == 2) mode = 1;
                else if (mem_to_mem[7:0] == 8'hFF) mode = 0;
                else if (mem_to_mem[7:0] == 8'h40 || mem_to_mem[7:0] == 8'h20) mode = 2;
            end
            pend = 1;
            cnt = LAT;
            req_cyc = cyc;
        end else if (pend) begin
            if (cnt == 0) begin
                mem_ready = 1'b1;
                mem_from_mem = resp;
                pend = 0;
                rdy_cyc = cyc;
            end else begin
                cnt--;
            end
        end
        req_prev = mem_req;
    end

    task automatic send(input logic [1:0] op, input logic [22:0] a, input logic [15:0] d, output int acc_cyc, output bit ok);
        ok = 0;
        acc_cyc = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        if (ok) begin
            cmd_valid = 1'b1;
            cmd_op = op;
            cmd_addr = a;
            cmd_data = d;
            acc_cyc = cyc;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output int dcyc, output bit ok);
        ok = 0;
        dcyc = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                dcyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cmd_ready, done, error, mem_req, mem_wren} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/done/err/req/wren=%b, required 10000", {cmd_ready, done, error, mem_req, mem_wren});
        end
        n_chk++;
        if (rdata !== 16'h0 || status !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h status=%h, required 0000 00", rdata, status);
        end
        n_chk++;
        if (mem_address !== 23'h0 || mem_to_mem !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h data=%h, required 0", mem_address, mem_to_mem);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rdy=%b req=%b, required 1 0", cmd_ready, mem_req);
        end
    endtask

    task automatic test_read_first();
        int a, d;
        bit ok;
        res_t r;
        exp_acc.push_back(acc_t'{1'b1, 23'h10, 16'h00FF});
        exp_acc.push_back(acc_t'{1'b0, 23'h10, 16'h0000});
        exp_res.push_back(res_t'{16'hBEEF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
        send(2'b00, 23'h10, 16'h0, a, ok);
        n_chk++;
        if (!ok || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read1_accept: ok=%0d rdy=%b, required 1 0", ok, cmd_ready);
        end
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || rdata !== r.rdata || error !== r.error) begin
            n_fail++;
            $display("FAIL read1_result: done=%0d rdata=%h err=%b, required 1 %h %b", ok, rdata, error, r.rdata, r.error);
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL read1_end: done=%b rdy=%b left=%0d, required 0 1 0", done, cmd_ready, exp_acc.size());
        end
    endtask

    task automatic test_read_array();
        int a, d;
        bit ok;
        res_t r;
        exp_acc.push_back(acc_t'{1'b0, 23'h11, 16'h0000});
        exp_res.push_back(res_t'{word_of(23'h11), 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
        send(2'b00, 23'h11, 16'h0, a, ok);
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || rdata !== r.rdata || error !== r.error) begin
            n_fail++;
            $display("FAIL read2_result: done=%0d rdata=%h err=%b, required 1 %h %b", ok, rdata, error, r.rdata, r.error);
        end
        n_chk++;
        if (req_cyc != a + 1 || d != rdy_cyc + 1 || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL read2_latency: req@%0d done@%0d left=%0d, required req@%0d done@%0d 0", req_cyc, d, exp_acc.size(), a + 1, rdy_cyc + 1);
        end
    endtask

    task automatic test_program();
        int a, d;
        bit ok;
        res_t r;
        poll_reads = 0;
        stat_q = '{8'h00, 8'h00, 8'h80};
        exp_acc.push_back(acc_t'{1'b1, 23'h200, 16'h0040});
        exp_acc.push_back(acc_t'{1'b1, 23'h200, 16'h1234});
        for (int i = 0; i < 3; i++) exp_acc.push_back(acc_t'{1'b0, 23'h200, 16'h0000});
        exp_res.push_back(res_t'{16'h0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1});
        send(2'b01, 23'h200, 16'h1234, a, ok);
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || status !== r.status || error !== r.error) begin
            n_fail++;
            $display("FAIL prog_result: done=%0d status=%h err=%b, required 1 %h %b", ok, status, error, r.status, r.error);
        end
        n_chk++;
        if (poll_reads != 3 || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL prog_polls: polls=%0d left=%0d, required 3 0", poll_reads, exp_acc.size());
        end
    endtask

    task automatic test_erase();
        int a, d;
        bit ok;
        res_t r;
        poll_reads = 0;
        stat_q = '{8'hA0};
        exp_acc.push_back(acc_t'{1'b1, 23'h10000, 16'h0020});
        exp_acc.push_back(acc_t'{1'b1, 23'h10000, 16'h00D0});
        exp_acc.push_back(acc_t'{1'b0, 23'h10000, 16'h0000});
        exp_res.push_back(res_t'{16'h0, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b1});
        send(2'b10, 23'h10000, 16'h0, a, ok);
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || status !== r.status || error !== r.error || poll_reads != 1) begin
            n_fail++;
            $display("FAIL erase_result: done=%0d status=%h err=%b polls=%0d, required 1 %h %b 1", ok, status, error, poll_reads, r.status, r.error);
        end
        exp_acc.push_back(acc_t'{1'b1, 23'h10, 16'h00FF});
        exp_acc.push_back(acc_t'{1'b0, 23'h10, 16'h0000});
        exp_res.push_back(res_t'{16'hBEEF, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0});
        send(2'b00, 23'h10, 16'h0, a, ok);
        n_chk++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL erase_err_clear: err=%b after accept, required 0", error);
        end
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || rdata !== r.rdata || status !== r.status || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL erase_reread: done=%0d rdata=%h status=%h left=%0d, required 1 %h %h 0", ok, rdata, status, exp_acc.size(), r.rdata, r.status);
        end
    endtask

    task automatic test_clear();
        int a, d;
        bit ok;
        res_t r;
        exp_acc.push_back(acc_t'{1'b1, 23'h0, 16'h0050});
        send(2'b11, 23'h0, 16'h0, a, ok);
        wait_done(d, ok);
        n_chk++;
        if (!ok || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL clear_done: done=%0d left=%0d, required 1 0", ok, exp_acc.size());
        end
        exp_acc.push_back(acc_t'{1'b1, 23'h12, 16'h00FF});
        exp_acc.push_back(acc_t'{1'b0, 23'h12, 16'h0000});
        exp_res.push_back(res_t'{word_of(23'h12), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        send(2'b00, 23'h12, 16'h0, a, ok);
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || rdata !== r.rdata || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL clear_reread: done=%0d rdata=%h left=%0d, required 1 %h 0", ok, rdata, exp_acc.size(), r.rdata);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        bit ok1, ok2;
        res_t r;
        for (int i = 0; i < 2; i++) begin
            exp_acc.push_back(acc_t'{1'b0, 23'h13, 16'h0000});
            exp_res.push_back(res_t'{word_of(23'h13), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        cmd_op = 2'b00;
        cmd_addr = 23'h13;
        cmd_valid = 1'b1;
        wait_done(d1, ok1);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok1 || rdata !== r.rdata) begin
            n_fail++;
            $display("FAIL b2b_first: done=%0d rdata=%h, required 1 %h", ok1, rdata, r.rdata);
        end
        wait_done(d2, ok2);
        cmd_valid = 1'b0;
        r = exp_res.pop_front();
        n_chk++;
        if (!ok2 || rdata !== r.rdata || req_cyc != d1 + 2) begin
            n_fail++;
            $display("FAIL b2b_second: done=%0d rdata=%h req@%0d, required 1 %h req@%0d", ok2, rdata, req_cyc, r.rdata, d1 + 2);
        end
        repeat (6) @(negedge clk);
        n_chk++;
        if (exp_acc.size() != 0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: left=%0d rdy=%b, required 0 1", exp_acc.size(), cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int a, d;
        bit ok;
        res_t r;
        poll_reads = 0;
        stat_q.delete();
        stat_stuck = 8'h00;
        exp_acc.push_back(acc_t'{1'b1, 23'h300, 16'h0040});
        exp_acc.push_back(acc_t'{1'b1, 23'h300, 16'hABCD});
        for (int i = 0; i < 5; i++) exp_acc.push_back(acc_t'{1'b0, 23'h300, 16'h0000});
        exp_res.push_back(res_t'{16'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1});
        send(2'b01, 23'h300, 16'hABCD, a, ok);
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || status !== r.status || error !== r.error) begin
            n_fail++;
            $display("FAIL timeout_result: done=%0d status=%h err=%b, required 1 %h %b", ok, status, error, r.status, r.error);
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (poll_reads != 5 || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_polls: polls=%0d left=%0d, required 5 0", poll_reads, exp_acc.size());
        end
    endtask

    task automatic test_reset_mid();
        int a, d, rc;
        bit ok, seen;
        res_t r;
        stat_q.delete();
        stat_stuck = 8'h00;
        exp_acc.push_back(acc_t'{1'b1, 23'h400, 16'h0040});
        exp_acc.push_back(acc_t'{1'b1, 23'h400, 16'h1111});
        exp_acc.push_back(acc_t'{1'b0, 23'h400, 16'h0000});
        send(2'b01, 23'h400, 16'h1111, a, ok);
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && !mem_wren) seen = 1;
        end
        #1 rst_n = 1'b0;
        rc = cyc;
        #1;
        n_chk++;
        if (!seen || mem_req !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: poll_seen=%0d req=%b rdy=%b done=%b, required 1 0 1 0", seen, mem_req, cmd_ready, done);
        end
        n_chk++;
        if (mem_address !== 23'h0 || mem_to_mem !== 16'h0 || mem_wren !== 1'b0 || status !== 8'h0 || error !== 1'b0 || rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_vals: addr=%h data=%h wren=%b st=%h err=%b rd=%h, required all 0", mem_address, mem_to_mem, mem_wren, status, error, rdata);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || mem_req || !cmd_ready) seen = 1;
        end
        n_chk++;
        if (seen || rdy_cyc <= rc || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL late_ready: disturbed=%0d ready@%0d reset@%0d left=%0d, required 0 ready>reset 0", seen, rdy_cyc, rc, exp_acc.size());
        end
        exp_acc.push_back(acc_t'{1'b1, 23'h10, 16'h00FF});
        exp_acc.push_back(acc_t'{1'b0, 23'h10, 16'h0000});
        exp_res.push_back(res_t'{16'hBEEF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1});
        send(2'b00, 23'h10, 16'h0, a, ok);
        wait_done(d, ok);
        r = exp_res.pop_front();
        n_chk++;
        if (!ok || rdata !== r.rdata || status !== r.status || error !== r.error || exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_read: done=%0d rdata=%h st=%h err=%b left=%0d, required 1 %h %h %b 0", ok, rdata, status, error, exp_acc.size(), r.rdata, r.status, r.error);
        end
    endtask

    initial begin
        test_reset();
        test_read_first();
        test_read_array();
        test_program();
        test_erase();
        test_clear();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
